// File: rtl/f3_gpu_engine.sv
// f3_gpu_engine
//   Image-display engine. Maps the VGA scan position into a square display
//   window, transforms the mapper's texel coordinate (mirror, rotation) into a
//   ROM address, selects the ROM image (including a timed wipe between the old
//   and the new image), and registers the final colour (optionally negated).
//
// Ports
//   sysclk              in   system clock, rising edge
//   reset               in   synchronous, active-high
//   instruction[2:0]    in   command code, taken when set=1 and not busy
//   set                 in   command strobe
//   busy                out  high while a wipe transition runs
//   display_addr        in   scan position {x, y}
//   mapper_pixel_x/y    in   texel column/row from the coordinate mapper
//   pixel_data          in   ROM colour for {image_index, pixel_addr}
//   mapper_display_addr out  display_addr forwarded to the mapper
//   pixel_addr          out  transformed ROM texel address (0 outside window)
//   image_index[2:0]    out  ROM image select
//   display_data        out  registered output colour (1 clock latency)
module f3_gpu_engine #(
    parameter int ADDR_W     = 11,
    parameter int IMG_BITS   = 4,
    parameter int NUM_IMAGES = 8,
    parameter int COLOR_W    = 3,
    parameter int WIN_X0     = 231,
    parameter int WIN_Y0     = 36,
    parameter int WIN_SIZE   = 481,
    parameter int STEP_W     = 4
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic [2:0]            instruction,
    input  logic                  set,
    output logic                  busy,
    input  logic [2*ADDR_W-1:0]   display_addr,
    input  logic [IMG_BITS-1:0]   mapper_pixel_x,
    input  logic [IMG_BITS-1:0]   mapper_pixel_y,
    input  logic [COLOR_W-1:0]    pixel_data,
    output logic [2*ADDR_W-1:0]   mapper_display_addr,
    output logic [2*IMG_BITS-1:0] pixel_addr,
    output logic [2:0]            image_index,
    output logic [COLOR_W-1:0]    display_data
);

    localparam int PIX_W = 2*IMG_BITS;
    localparam logic [IMG_BITS-1:0] MAXV     = {IMG_BITS{1'b1}};
    localparam logic [2:0]          LAST_IMG = 3'(NUM_IMAGES-1);
    localparam logic [ADDR_W-1:0]   X_LO     = ADDR_W'(WIN_X0);
    localparam logic [ADDR_W-1:0]   X_HI     = ADDR_W'(WIN_X0+WIN_SIZE-1);
    localparam logic [ADDR_W-1:0]   Y_LO     = ADDR_W'(WIN_Y0);
    localparam logic [ADDR_W-1:0]   Y_HI     = ADDR_W'(WIN_Y0+WIN_SIZE-1);

    typedef enum logic [1:0] {S_IDLE, S_WIPE_F, S_WIPE_B} state_t;

    state_t               state_q, state_d;
    logic [2:0]           cur_q, cur_d, old_q, old_d;
    logic [1:0]           rot_q, rot_d;
    logic                 mir_q, mir_d, neg_q, neg_d;
    logic [PIX_W-1:0]     idx_q, idx_d;
    logic [STEP_W-1:0]    pre_q, pre_d;
    logic [COLOR_W-1:0]   dd_q, dd_d;

    logic [ADDR_W-1:0]    scan_x, scan_y;
    logic                 in_win;
    logic [IMG_BITS-1:0]  mx, ta, tb;
    logic [PIX_W-1:0]     tex;
    logic [2:0]           img;

    assign scan_x = display_addr[2*ADDR_W-1:ADDR_W];
    assign scan_y = display_addr[ADDR_W-1:0];
    assign in_win = (scan_x >= X_LO) && (scan_x <= X_HI) &&
                    (scan_y >= Y_LO) && (scan_y <= Y_HI);

    // Mirror first, then rotate in quarter turns.
    always_comb begin
        mx = mir_q ? (MAXV - mapper_pixel_x) : mapper_pixel_x;
        case (rot_q)
            2'd0:    begin ta = mx;                    tb = mapper_pixel_y;        end
            2'd1:    begin ta = mapper_pixel_y;        tb = MAXV - mx;             end
            2'd2:    begin ta = MAXV - mx;             tb = MAXV - mapper_pixel_y; end
            default: begin ta = MAXV - mapper_pixel_y; tb = mx;                    end
        endcase
        tex = {ta, tb};
    end

    // During a wipe the texels already swept show the new image.
    always_comb begin
        img = cur_q;
        if (in_win) begin
            if (state_q == S_WIPE_F && !(tex < idx_q)) img = old_q;
            if (state_q == S_WIPE_B && !(tex > idx_q)) img = old_q;
        end
    end

    assign mapper_display_addr = display_addr;
    assign pixel_addr          = in_win ? tex : '0;
    assign image_index         = img;
    assign busy                = (state_q != S_IDLE);
    assign display_data        = dd_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        old_d   = old_q;
        rot_d   = rot_q;
        mir_d   = mir_q;
        neg_d   = neg_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        dd_d    = in_win ? (neg_q ? ~pixel_data : pixel_data) : '0;
        case (state_q)
            S_IDLE: begin
                if (set) begin
                    case (instruction)
                        3'd1: begin
                            old_d   = cur_q;
                            cur_d   = (cur_q == 3'd0) ? LAST_IMG : cur_q - 3'd1;
                            rot_d   = '0;
                            mir_d   = 1'b0;
                            neg_d   = 1'b0;
                            idx_d   = '1;
                            pre_d   = '0;
                            state_d = S_WIPE_B;
                        end
                        3'd2: begin
                            old_d   = cur_q;
                            cur_d   = (cur_q == LAST_IMG) ? 3'd0 : cur_q + 3'd1;
                            rot_d   = '0;
                            mir_d   = 1'b0;
                            neg_d   = 1'b0;
                            idx_d   = '0;
                            pre_d   = '0;
                            state_d = S_WIPE_F;
                        end
                        3'd3: rot_d = rot_q + 2'd1;
                        3'd4: neg_d = ~neg_q;
                        3'd5: mir_d = ~mir_q;
                        3'd6: begin
                            cur_d = '0;
                            rot_d = '0;
                            mir_d = 1'b0;
                            neg_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_WIPE_F: begin
                pre_d = pre_q + STEP_W'(1);
                if (&pre_q) begin
                    idx_d = idx_q + PIX_W'(1);
                    if (&idx_q) state_d = S_IDLE;
                end
            end
            S_WIPE_B: begin
                pre_d = pre_q + STEP_W'(1);
                if (&pre_q) begin
                    idx_d = idx_q - PIX_W'(1);
                    if (idx_q == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            old_q   <= '0;
            rot_q   <= '0;
            mir_q   <= 1'b0;
            neg_q   <= 1'b0;
            idx_q   <= '0;
            pre_q   <= '0;
            dd_q    <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            old_q   <= old_d;
            rot_q   <= rot_d;
            mir_q   <= mir_d;
            neg_q   <= neg_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            dd_q    <= dd_d;
        end
    end

endmodule

// File: tb/tb_f3_gpu_engine.sv
module tb_f3_gpu_engine;

    localparam int WX0 = 231, WY0 = 36, WS = 481;
    localparam int WIPE_LEN = 256 * 16;

    logic        sysclk = 0, reset = 0, set = 0;
    logic [2:0]  instruction = 0;
    logic        busy;
    logic [21:0] display_addr;
    logic [3:0]  mapper_pixel_x = 0, mapper_pixel_y = 0;
    logic [2:0]  pixel_data = 0;
    logic [21:0] mapper_display_addr;
    logic [7:0]  pixel_addr;
    logic [2:0]  image_index;
    logic [2:0]  display_data;

    int checks = 0, errors = 0;
    int sx = 0, sy = 0;

    // Reference model state
    int  m_cur, m_old, m_rot, m_t;
    bit  m_mir, m_neg, m_wipe, m_fwd;
    logic [2:0] m_dd;

    f3_gpu_engine dut (
        .sysclk(sysclk), .reset(reset), .instruction(instruction), .set(set),
        .busy(busy), .display_addr(display_addr),
        .mapper_pixel_x(mapper_pixel_x), .mapper_pixel_y(mapper_pixel_y),
        .pixel_data(pixel_data), .mapper_display_addr(mapper_display_addr),
        .pixel_addr(pixel_addr), .image_index(image_index),
        .display_data(display_data)
    );

    always #5 sysclk = ~sysclk;

    assign display_addr = {11'(sx), 11'(sy)};

    function automatic bit win();
        return sx >= WX0 && sx <= WX0 + WS - 1 && sy >= WY0 && sy <= WY0 + WS - 1;
    endfunction

    // Texel address: mirror the column, then rotate the (col,row) pair a
    // quarter turn m_rot times.
    function automatic logic [7:0] exp_addr();
        int a, b, t;
        if (!win()) return 8'd0;
        a = m_mir ? 15 - int'(mapper_pixel_x) : int'(mapper_pixel_x);
        b = int'(mapper_pixel_y);
        for (int r = 0; r < m_rot; r++) begin
            t = a; a = b; b = 15 - t;
        end
        return 8'(a * 16 + b);
    endfunction

    function automatic logic [2:0] exp_img();
        int idx, pa;
        if (!win() || !m_wipe) return 3'(m_cur);
        idx = m_fwd ? m_t / 16 : 255 - m_t / 16;
        pa  = int'(exp_addr());
        if (m_fwd) return (pa < idx) ? 3'(m_cur) : 3'(m_old);
        return (pa > idx) ? 3'(m_cur) : 3'(m_old);
    endfunction

    task automatic model_reset();
        m_cur = 0; m_old = 0; m_rot = 0; m_t = 0;
        m_mir = 0; m_neg = 0; m_wipe = 0; m_fwd = 0; m_dd = 0;
    endtask

    // One clock: update the model from the inputs present at the edge,
    // then advance past the edge. Any command strobe is one-shot.
    task automatic step();
        m_dd = win() ? (m_neg ? ~pixel_data : pixel_data) : 3'd0;
        if (m_wipe) begin
            m_t++;
            if (m_t == WIPE_LEN) m_wipe = 0;
        end else if (set) begin
            case (instruction)
                3'd1, 3'd2: begin
                    m_old = m_cur;
                    m_cur = (instruction == 3'd2) ? (m_cur + 1) % 8 : (m_cur + 7) % 8;
                    m_rot = 0; m_mir = 0; m_neg = 0;
                    m_wipe = 1; m_fwd = (instruction == 3'd2); m_t = 0;
                end
                3'd3: m_rot = (m_rot + 1) % 4;
                3'd4: m_neg = !m_neg;
                3'd5: m_mir = !m_mir;
                3'd6: begin m_cur = 0; m_rot = 0; m_mir = 0; m_neg = 0; end
                default: ;
            endcase
        end
        @(posedge sysclk); #1;
        set = 0;
    endtask

    task automatic cmd(input int code);
        set = 1; instruction = 3'(code);
        step();
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge sysclk); #1;
        reset = 0; set = 0;
        model_reset();
    endtask

    task automatic test_reset();
        sx = 0; sy = 0;
        do_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (display_data !== 3'd0) begin errors++; $display("FAIL reset_dd: got %h want 0", display_data); end
        checks++; if (image_index !== 3'd0) begin errors++; $display("FAIL reset_img: got %h want 0", image_index); end
        pixel_data = 3'b111;
        step();
        checks++; if (display_data !== 3'd0) begin errors++; $display("FAIL reset_dd_out: got %h want 0", display_data); end
    endtask

    task automatic test_window();
        int xs[7] = '{231, 230, 711, 712, 231, 231, 400};
        int ys[7] = '{36,  36,  516, 516, 35,  516, 517};
        logic [2:0] want[7] = '{3'b101, 3'b000, 3'b101, 3'b000, 3'b000, 3'b101, 3'b000};
        mapper_pixel_x = 0; mapper_pixel_y = 0; pixel_data = 3'b101;
        for (int i = 0; i < 7; i++) begin
            sx = xs[i]; sy = ys[i];
            step();
            checks++;
            if (display_data !== want[i] || display_data !== m_dd) begin
                errors++;
                $display("FAIL window_%0d_%0d: got %b want %b", xs[i], ys[i], display_data, want[i]);
            end
        end
    endtask

    task automatic test_transforms();
        sx = 300; sy = 100;
        cmd(3);
        mapper_pixel_x = 2; mapper_pixel_y = 5; #1;
        checks++; if (pixel_addr !== {4'd5, 4'd13}) begin errors++; $display("FAIL rot1_addr: got %h want 5d", pixel_addr); end
        cmd(5); #1;
        checks++; if (pixel_addr !== {4'd5, 4'd2}) begin errors++; $display("FAIL rot1_mirror_addr: got %h want 52", pixel_addr); end
        cmd(4);
        pixel_data = 3'b010;
        step();
        checks++; if (display_data !== 3'b101) begin errors++; $display("FAIL neg_dd: got %b want 101", display_data); end
        cmd(6);
    endtask

    task automatic test_random();
        int ops[6] = '{0, 3, 4, 5, 6, 7};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                sx = $urandom_range(WX0, WX0 + WS - 1); sy = $urandom_range(WY0, WY0 + WS - 1);
            end else begin
                sx = $urandom_range(0, 799); sy = $urandom_range(0, 599);
            end
            mapper_pixel_x = 4'($urandom); mapper_pixel_y = 4'($urandom);
            pixel_data = 3'($urandom);
            set = 1'($urandom_range(0, 1)); instruction = 3'(ops[$urandom_range(0, 5)]);
            #1;
            checks++; if (pixel_addr !== exp_addr()) begin errors++; $display("FAIL rnd_addr: got %h want %h", pixel_addr, exp_addr()); end
            checks++; if (image_index !== exp_img()) begin errors++; $display("FAIL rnd_img: got %h want %h", image_index, exp_img()); end
            checks++; if (mapper_display_addr !== display_addr) begin errors++; $display("FAIL rnd_map: got %h want %h", mapper_display_addr, display_addr); end
            step();
            checks++; if (display_data !== m_dd) begin errors++; $display("FAIL rnd_dd: got %b want %b", display_data, m_dd); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy: got %b want 0", busy); end
        end
        cmd(6);
    endtask

    // Runs the current wipe to completion, checking the texel split every
    // cycle; returns the number of busy cycles observed.
    task automatic run_wipe(output int n, input bit probe);
        n = 0;
        while (busy === 1'b1 && n < WIPE_LEN + 200) begin
            sx = $urandom_range(WX0, WX0 + WS - 1); sy = $urandom_range(WY0, WY0 + WS - 1);
            mapper_pixel_x = 4'($urandom); mapper_pixel_y = 4'($urandom);
            pixel_data = 3'($urandom);
            if (n == 5) begin set = 1; instruction = 3'd3; end
            #1;
            if (probe && m_t == 2032) begin
                mapper_pixel_x = 9; mapper_pixel_y = 0; #1;
                checks++; if (image_index !== 3'd7) begin errors++; $display("FAIL wipe_mid_90: got %0d want 7", image_index); end
                mapper_pixel_x = 1; #1;
                checks++; if (image_index !== 3'd0) begin errors++; $display("FAIL wipe_mid_10: got %0d want 0", image_index); end
            end
            if (image_index !== exp_img()) begin
                errors++; $display("FAIL wipe_img t=%0d: got %0d want %0d", m_t, image_index, exp_img());
            end
            step();
            if (display_data !== m_dd) begin
                errors++; $display("FAIL wipe_dd: got %b want %b", display_data, m_dd);
            end
            n++;
        end
        checks += 2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wipe_timeout: busy %b after %0d cycles", busy, n); end
    endtask

    task automatic test_prev_wipe();
        int n;
        cmd(6);
        sx = 0; sy = 0;
        cmd(1);
        run_wipe(n, 1);
        checks++; if (n !== WIPE_LEN) begin errors++; $display("FAIL prev_busy_len: got %0d want %0d", n, WIPE_LEN); end
        sx = 0; sy = 0; #1;
        checks++; if (image_index !== 3'd7) begin errors++; $display("FAIL prev_img: got %0d want 7", image_index); end
    endtask

    task automatic test_back_to_back();
        int n;
        // cur_img is 7 here: NEXT wraps to 0; a ROT strobed mid-wipe is dropped.
        cmd(2);
        run_wipe(n, 0);
        checks++; if (n !== WIPE_LEN) begin errors++; $display("FAIL next_busy_len: got %0d want %0d", n, WIPE_LEN); end
        sx = 0; sy = 0; #1;
        checks++; if (image_index !== 3'd0) begin errors++; $display("FAIL next_wrap_img: got %0d want 0", image_index); end
        sx = 300; sy = 100; mapper_pixel_x = 2; mapper_pixel_y = 5; #1;
        checks++; if (pixel_addr !== {4'd2, 4'd5}) begin errors++; $display("FAIL busy_drop_rot: got %h want 25", pixel_addr); end
        cmd(2);
        for (int i = 0; i < 100; i++) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL next2_busy: got %b want 1", busy); end
        do_reset();
        sx = 0; sy = 0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_wipe_busy: got %b want 0", busy); end
        checks++; if (image_index !== 3'd0) begin errors++; $display("FAIL reset_mid_wipe_img: got %0d want 0", image_index); end
    endtask

    task automatic test_home();
        sx = 300; sy = 100;
        cmd(2);
        for (int i = 0; i < WIPE_LEN; i++) step();
        cmd(3); cmd(4); cmd(5); cmd(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL home_busy: got %b want 0", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL home_busy2: got %b want 0", busy); end
        mapper_pixel_x = 2; mapper_pixel_y = 5; pixel_data = 3'b011; #1;
        checks++; if (pixel_addr !== {4'd2, 4'd5}) begin errors++; $display("FAIL home_addr: got %h want 25", pixel_addr); end
        checks++; if (image_index !== 3'd0) begin errors++; $display("FAIL home_img: got %0d want 0", image_index); end
        step();
        checks++; if (display_data !== 3'b011) begin errors++; $display("FAIL home_dd: got %b want 011", display_data); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_window();
        test_transforms();
        test_random();
        test_prev_wipe();
        test_back_to_back();
        test_home();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
